beverage_dispenser: RTL

//  Mechanism-side responder to the vending_machine FSM. Consumes its one-cycle

---
 rtl/beverage_dispenser_pkg.sv | 17 +
 rtl/beverage_dispenser_pulse_stretcher.sv | 38 +++
 rtl/beverage_dispenser.sv | 127 ++++++++++++
 3 files changed

// File: rtl/beverage_dispenser_pkg.sv
// Shared definitions for the beverage dispenser: FSM state encoding and
// default timing constants.
package beverage_dispenser_pkg;

  typedef enum logic [1:0] {
    DSP_IDLE   = 2'd0,
    DSP_SPIN   = 2'd1,
    DSP_SETTLE = 2'd2,
    DSP_FAULT  = 2'd3
  } dsp_state_e;

  localparam int DEF_MOTOR_CYCLES  = 8;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_RET_CYCLES    = 4;
  localparam int DEF_QDEPTH        = 3;

endpackage

// File: rtl/beverage_dispenser_pulse_stretcher.sv
// Retriggerable pulse stretcher: a one-cycle trig yields LEN cycles of out,
// starting the cycle after trig; a trig while active restarts the count.
module pulse_stretcher #(
  parameter int LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out
);

  localparam int CW = $clog2(LEN + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q;

  always_comb begin
    cnt_d = cnt_q;
    if (trig) begin
      cnt_d = CW'(LEN);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      out_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out_q <= (cnt_d != '0);
    end
  end

  assign out = out_q;

endmodule

// File: rtl/beverage_dispenser.sv
// Mechanism-side dispenser: queues beverage requests, spins the motor until
// the drop sensor confirms delivery, faults on timeout, pulses coin return.
module beverage_dispenser
  import beverage_dispenser_pkg::*;
#(
  parameter int MOTOR_CYCLES  = DEF_MOTOR_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int RET_CYCLES    = DEF_RET_CYCLES,
  parameter int QDEPTH        = DEF_QDEPTH,
  parameter int QW            = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          beverage,
  input  logic          refund,
  input  logic          drop_sensor,
  input  logic          fault_clr,
  output logic          motor_on,
  output logic          coin_return,
  output logic          busy,
  output logic          fault,
  output logic [QW-1:0] pending,
  output logic          req_drop
);

  localparam int TW = $clog2(MOTOR_CYCLES);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  dsp_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [SW-1:0] stl_q, stl_d;
  logic [QW-1:0] pending_q, pending_d;
  logic          motor_on_q, fault_q, req_drop_q, req_drop_d;
  logic          dec, accept;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    stl_d   = stl_q;
    dec     = 1'b0;
    case (state_q)
      DSP_IDLE: begin
        if (pending_q != '0) begin
          state_d = DSP_SPIN;
          tmr_d   = '0;
        end
      end
      DSP_SPIN: begin
        tmr_d = tmr_q + TW'(1);
        // A confirmed drop beats a timeout landing on the same edge.
        if (drop_sensor) begin
          state_d = DSP_SETTLE;
          stl_d   = '0;
          dec     = 1'b1;
        end else if (tmr_q == TW'(MOTOR_CYCLES - 1)) begin
          state_d = DSP_FAULT;
          tmr_d   = '0;
        end
      end
      DSP_SETTLE: begin
        stl_d = stl_q + SW'(1);
        // Go straight back to SPIN so the motor-off gap is exactly SETTLE_CYCLES.
        if (stl_q == SW'(SETTLE_CYCLES - 1)) begin
          stl_d = '0;
          if (pending_q != '0) begin
            state_d = DSP_SPIN;
            tmr_d   = '0;
          end else begin
            state_d = DSP_IDLE;
          end
        end
      end
      DSP_FAULT: begin
        if (fault_clr) begin
          state_d = DSP_IDLE;
        end
      end
      default: state_d = DSP_IDLE;
    endcase
  end

  // A delivery on the same edge frees a slot, so a request at full depth is kept.
  always_comb begin
    accept     = beverage && ((pending_q != QW'(QDEPTH)) || dec);
    req_drop_d = beverage && !accept;
    pending_d  = pending_q;
    if (accept && !dec) begin
      pending_d = pending_q + QW'(1);
    end else if (dec && !accept && (pending_q != '0)) begin
      pending_d = pending_q - QW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DSP_IDLE;
      tmr_q      <= '0;
      stl_q      <= '0;
      pending_q  <= '0;
      motor_on_q <= 1'b0;
      fault_q    <= 1'b0;
      req_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      stl_q      <= stl_d;
      pending_q  <= pending_d;
      motor_on_q <= (state_d == DSP_SPIN);
      fault_q    <= (state_d == DSP_FAULT);
      req_drop_q <= req_drop_d;
    end
  end

  pulse_stretcher #(.LEN(RET_CYCLES)) u_coin_ret (
    .clk  (clk),
    .rst  (rst),
    .trig (refund),
    .out  (coin_return)
  );

  assign motor_on = motor_on_q;
  assign fault    = fault_q;
  assign req_drop = req_drop_q;
  assign pending  = pending_q;
  assign busy     = (state_q != DSP_IDLE) || (pending_q != '0);

endmodule
